// File: rtl/md_sequencer.sv
// HI/LO owner and multi-cycle multiply/divide sequencer for the 5-stage MIPS pipeline.
// Optional madd/maddu support is compiled in when MD_MADD_EN is defined.
module md_sequencer #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  op_D,
    input  logic [5:0]  funct_D,
    input  logic [5:0]  op_E,
    input  logic [5:0]  funct_E,
    input  logic        valid_E,
    input  logic [31:0] rs_E,
    input  logic [31:0] rt_E,
    output logic        start,
    output logic        busy,
    output logic        stall_D,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] md_rdata
);

    localparam logic [5:0] OP_SPECIAL  = 6'b000000;
    localparam logic [5:0] OP_SPECIAL2 = 6'b011100;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MADD  = 6'b000000;
    localparam logic [5:0] F_MADDU = 6'b000001;

    localparam logic [4:0] MUL_LOAD = 5'(MULT_CYCLES - 1);
    localparam logic [4:0] DIV_LOAD = 5'(DIV_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } state_t;

    state_t      state_q;
    logic [4:0]  cnt_q;
    logic [31:0] hi_q, lo_q;
    logic [31:0] pend_hi_q, pend_lo_q;
    logic        busy_q;

    logic        start_class_E;
    logic        use_div_d;
    logic        mthi_E, mtlo_E;
    logic [31:0] res_hi_d, res_lo_d;

    function automatic logic is_hilo(input logic [5:0] op, input logic [5:0] fn);
        logic r;
        r = 1'b0;
        if (op == OP_SPECIAL)
            r = (fn == F_MFHI) || (fn == F_MTHI) || (fn == F_MFLO) || (fn == F_MTLO) ||
                (fn == F_MULT) || (fn == F_MULTU) || (fn == F_DIV) || (fn == F_DIVU);
`ifdef MD_MADD_EN
        if (op == OP_SPECIAL2)
            r = (fn == F_MADD) || (fn == F_MADDU);
`endif
        return r;
    endfunction

    // Decode of the E-stage instruction and the 64-bit result it would commit.
    always_comb begin
        logic signed [63:0] prod_s;
        logic        [63:0] prod_u;
        logic signed [31:0] quot_s, rem_s;
        start_class_E = 1'b0;
        use_div_d     = 1'b0;
        mthi_E        = 1'b0;
        mtlo_E        = 1'b0;
        res_hi_d      = 32'h0;
        res_lo_d      = 32'h0;
        prod_s = $signed({{32{rs_E[31]}}, rs_E}) * $signed({{32{rt_E[31]}}, rt_E});
        prod_u = {32'h0, rs_E} * {32'h0, rt_E};
        quot_s = 32'sh0;
        rem_s  = 32'sh0;
        if (rt_E != 32'h0 && !(rs_E == 32'h80000000 && rt_E == 32'hFFFFFFFF)) begin
            quot_s = $signed(rs_E) / $signed(rt_E);
            rem_s  = $signed(rs_E) % $signed(rt_E);
        end
        if (op_E == OP_SPECIAL) begin
            case (funct_E)
                F_MTHI:  mthi_E = 1'b1;
                F_MTLO:  mtlo_E = 1'b1;
                F_MULT: begin
                    start_class_E = 1'b1;
                    {res_hi_d, res_lo_d} = prod_s;
                end
                F_MULTU: begin
                    start_class_E = 1'b1;
                    {res_hi_d, res_lo_d} = prod_u;
                end
                F_DIV: begin
                    start_class_E = 1'b1;
                    use_div_d     = 1'b1;
                    if (rt_E == 32'h0) begin
                        res_lo_d = 32'hFFFFFFFF;
                        res_hi_d = rs_E;
                    end else if (rs_E == 32'h80000000 && rt_E == 32'hFFFFFFFF) begin
                        res_lo_d = 32'h80000000;
                        res_hi_d = 32'h0;
                    end else begin
                        res_lo_d = quot_s;
                        res_hi_d = rem_s;
                    end
                end
                F_DIVU: begin
                    start_class_E = 1'b1;
                    use_div_d     = 1'b1;
                    if (rt_E == 32'h0) begin
                        res_lo_d = 32'hFFFFFFFF;
                        res_hi_d = rs_E;
                    end else begin
                        res_lo_d = rs_E / rt_E;
                        res_hi_d = rs_E % rt_E;
                    end
                end
                default: ;
            endcase
        end
`ifdef MD_MADD_EN
        else if (op_E == OP_SPECIAL2) begin
            // Accumulate onto the HI/LO value present at start, wrapping at 64 bits.
            if (funct_E == F_MADD) begin
                start_class_E = 1'b1;
                {res_hi_d, res_lo_d} = {hi_q, lo_q} + prod_s;
            end else if (funct_E == F_MADDU) begin
                start_class_E = 1'b1;
                {res_hi_d, res_lo_d} = {hi_q, lo_q} + prod_u;
            end
        end
`endif
    end

    assign start    = valid_E && start_class_E && (state_q == S_IDLE);
    assign busy     = busy_q;
    assign stall_D  = (start || busy_q) && is_hilo(op_D, funct_D);
    assign hi       = hi_q;
    assign lo       = lo_q;
    assign md_rdata = (op_E == OP_SPECIAL && funct_E == F_MFHI) ? hi_q : lo_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= 5'd0;
            hi_q      <= 32'h0;
            lo_q      <= 32'h0;
            pend_hi_q <= 32'h0;
            pend_lo_q <= 32'h0;
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        pend_hi_q <= res_hi_d;
                        pend_lo_q <= res_lo_d;
                        cnt_q     <= use_div_d ? DIV_LOAD : MUL_LOAD;
                        state_q   <= use_div_d ? S_DIV : S_MUL;
                        busy_q    <= 1'b1;
                    end else if (valid_E && mthi_E) begin
                        hi_q <= rs_E;
                    end else if (valid_E && mtlo_E) begin
                        lo_q <= rs_E;
                    end
                end
                S_MUL, S_DIV: begin
                    if (cnt_q != 5'd0) begin
                        cnt_q <= cnt_q - 5'd1;
                    end else begin
                        hi_q    <= pend_hi_q;
                        lo_q    <= pend_lo_q;
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_md_sequencer.sv
// Directed self-checking bench for md_sequencer (build with MD_MADD_EN to cover madd/maddu).
module tb_md_sequencer;

    localparam int MC = 5;
    localparam int DC = 10;

    localparam logic [5:0] SP   = 6'b000000;
    localparam logic [5:0] SP2  = 6'b011100;
    localparam logic [5:0] MFHI = 6'b010000;
    localparam logic [5:0] MTHI = 6'b010001;
    localparam logic [5:0] MFLO = 6'b010010;
    localparam logic [5:0] MTLO = 6'b010011;
    localparam logic [5:0] MULT = 6'b011000;
    localparam logic [5:0] MULTU= 6'b011001;
    localparam logic [5:0] DIV  = 6'b011010;
    localparam logic [5:0] DIVU = 6'b011011;
    localparam logic [5:0] ADD  = 6'b100000;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  op_D, funct_D, op_E, funct_E;
    logic        valid_E;
    logic [31:0] rs_E, rt_E;
    logic        start, busy, stall_D;
    logic [31:0] hi, lo, md_rdata;

    int total = 0;
    int bad   = 0;

    md_sequencer #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset),
        .op_D(op_D), .funct_D(funct_D),
        .op_E(op_E), .funct_E(funct_E), .valid_E(valid_E),
        .rs_E(rs_E), .rt_E(rt_E),
        .start(start), .busy(busy), .stall_D(stall_D),
        .hi(hi), .lo(lo), .md_rdata(md_rdata)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_e(input logic [5:0] op, input logic [5:0] fn, input logic v,
                           input logic [31:0] a, input logic [31:0] b);
        op_E = op; funct_E = fn; valid_E = v; rs_E = a; rt_E = b;
    endtask

    task automatic drive_d(input logic [5:0] op, input logic [5:0] fn);
        op_D = op; funct_D = fn;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        drive_d(SP, ADD);
        drive_e(SP, 6'b0, 1'b0, 32'h0, 32'h0);
        tick;
        tick;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b exp 0", busy); end
        total++; if (hi !== 32'h0) begin bad++; $display("FAIL reset_hi: got %h exp 0", hi); end
        total++; if (lo !== 32'h0) begin bad++; $display("FAIL reset_lo: got %h exp 0", lo); end
        total++; if (start !== 1'b0 || stall_D !== 1'b0) begin
            bad++; $display("FAIL reset_start_stall: got %b%b exp 00", start, stall_D);
        end
        reset = 1'b0;
        tick;
    endtask

    // Issue one start-class op, keep a same-class op in E while busy, check commit.
    task automatic run_op(input string name, input logic [5:0] op, input logic [5:0] fn,
                          input logic [31:0] a, input logic [31:0] b, input int n,
                          input logic [31:0] e_hi, input logic [31:0] e_lo);
        drive_d(SP, ADD);
        drive_e(op, fn, 1'b1, a, b);
        #1;
        total++; if (start !== 1'b1) begin bad++; $display("FAIL %s_start: got %b exp 1", name, start); end
        for (int c = 1; c <= n; c++) begin
            tick;
            drive_e(op, fn, 1'b1, ~a, b + 32'd1);
            #1;
            total++;
            if (busy !== 1'b1 || start !== 1'b0 || stall_D !== 1'b0) begin
                bad++;
                $display("FAIL %s_busy_c%0d: got busy=%b start=%b stall=%b exp 1 0 0", name, c, busy, start, stall_D);
            end
        end
        tick;
        drive_e(SP, 6'b0, 1'b0, 32'h0, 32'h0);
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL %s_done_busy: got %b exp 0", name, busy); end
        total++; if (hi !== e_hi) begin bad++; $display("FAIL %s_hi: got %h exp %h", name, hi, e_hi); end
        total++; if (lo !== e_lo) begin bad++; $display("FAIL %s_lo: got %h exp %h", name, lo, e_lo); end
        tick;
    endtask

    task automatic test_mult_stall;
        drive_d(SP, MFLO);
        drive_e(SP, MULT, 1'b1, 32'hFFFFFFFF, 32'd2);
        #1;
        total++; if (start !== 1'b1 || stall_D !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL stall_c0: got start=%b stall=%b busy=%b exp 1 1 0", start, stall_D, busy);
        end
        for (int c = 1; c <= MC; c++) begin
            tick;
            drive_e(SP, 6'b0, 1'b0, 32'h0, 32'h0);
            #1;
            total++; if (busy !== 1'b1 || stall_D !== 1'b1) begin
                bad++; $display("FAIL stall_c%0d: got busy=%b stall=%b exp 1 1", c, busy, stall_D);
            end
        end
        tick;
        #1;
        total++; if (busy !== 1'b0 || stall_D !== 1'b0) begin
            bad++; $display("FAIL stall_c6: got busy=%b stall=%b exp 0 0", busy, stall_D);
        end
        total++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFE) begin
            bad++; $display("FAIL mult_result: got %h_%h exp ffffffff_fffffffe", hi, lo);
        end
        tick;
        drive_d(SP, ADD);
        drive_e(SP, MFLO, 1'b1, 32'h0, 32'h0);
        #1;
        total++; if (md_rdata !== 32'hFFFFFFFE) begin bad++; $display("FAIL mflo_read: got %h exp fffffffe", md_rdata); end
        drive_e(SP, MFHI, 1'b1, 32'h0, 32'h0);
        #1;
        total++; if (md_rdata !== 32'hFFFFFFFF) begin bad++; $display("FAIL mfhi_read: got %h exp ffffffff", md_rdata); end
        tick;
    endtask

    task automatic test_mthi_mtlo;
        drive_e(SP, MTHI, 1'b1, 32'h12345678, 32'h0);
        #1;
        total++; if (start !== 1'b0) begin bad++; $display("FAIL mthi_start: got %b exp 0", start); end
        tick;
        drive_e(SP, MFHI, 1'b1, 32'h0, 32'h0);
        #1;
        total++; if (hi !== 32'h12345678 || busy !== 1'b0) begin
            bad++; $display("FAIL mthi_write: got hi=%h busy=%b exp 12345678 0", hi, busy);
        end
        total++; if (md_rdata !== 32'h12345678) begin bad++; $display("FAIL mfhi_after_mthi: got %h exp 12345678", md_rdata); end
        drive_e(SP, MTLO, 1'b0, 32'hDEADBEEF, 32'h0);
        tick;
        #1;
        total++; if (lo !== 32'hFFFFFFFE) begin bad++; $display("FAIL mtlo_bubble: got %h exp fffffffe", lo); end
        drive_e(SP, MTLO, 1'b1, 32'hAABBCCDD, 32'h0);
        tick;
        drive_e(SP, 6'b0, 1'b0, 32'h0, 32'h0);
        #1;
        total++; if (lo !== 32'hAABBCCDD || hi !== 32'h12345678) begin
            bad++; $display("FAIL mtlo_write: got %h_%h exp 12345678_aabbccdd", hi, lo);
        end
        tick;
    endtask

    task automatic test_reset_mid;
        drive_d(SP, ADD);
        drive_e(SP, DIV, 1'b1, 32'd100, 32'd7);
        for (int c = 1; c <= 4; c++) begin
            tick;
            drive_e(SP, 6'b0, 1'b0, 32'h0, 32'h0);
        end
        #1;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rst_mid_pre_busy: got %b exp 1", busy); end
        reset = 1'b1;
        #1;
        total++; if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
            bad++; $display("FAIL rst_mid_now: got busy=%b hi=%h lo=%h exp 0 0 0", busy, hi, lo);
        end
        tick;
        reset = 1'b0;
        for (int c = 0; c < DC + 3; c++) begin
            tick;
            total++; if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
                bad++; $display("FAIL rst_mid_after_c%0d: got busy=%b hi=%h lo=%h exp 0 0 0", c, busy, hi, lo);
            end
        end
    endtask

`ifdef MD_MADD_EN
    task automatic test_madd;
        drive_e(SP, MTHI, 1'b1, 32'h0, 32'h0);
        tick;
        drive_e(SP, MTLO, 1'b1, 32'd5, 32'h0);
        tick;
        drive_d(SP2, 6'b000000);
        drive_e(SP, 6'b0, 1'b0, 32'h0, 32'h0);
        #1;
        total++; if (stall_D !== 1'b0) begin bad++; $display("FAIL madd_idle_stall: got %b exp 0", stall_D); end
        run_op("madd", SP2, 6'b000000, 32'd3, 32'd4, MC, 32'h0, 32'd17);
        run_op("maddu", SP2, 6'b000001, 32'hFFFFFFFF, 32'd2, MC, 32'h2, 32'h0000000F);
        run_op("madd_neg", SP2, 6'b000000, 32'hFFFFFFFF, 32'd2, MC, 32'h2, 32'h0000000D);
    endtask
`else
    task automatic test_madd;
        drive_d(SP2, 6'b000000);
        drive_e(SP2, 6'b000001, 1'b1, 32'd3, 32'd4);
        #1;
        total++; if (start !== 1'b0 || stall_D !== 1'b0) begin
            bad++; $display("FAIL madd_off_start: got start=%b stall=%b exp 0 0", start, stall_D);
        end
        tick;
        #1;
        total++; if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
            bad++; $display("FAIL madd_off_state: got busy=%b hi=%h lo=%h exp 0 0 0", busy, hi, lo);
        end
        drive_d(SP, ADD);
        drive_e(SP, 6'b0, 1'b0, 32'h0, 32'h0);
        tick;
    endtask
`endif

    initial begin
        test_reset;
        test_mult_stall;
        test_mthi_mtlo;
        run_op("multu", SP, MULTU, 32'hFFFFFFFF, 32'd2, MC, 32'h00000001, 32'hFFFFFFFE);
        run_op("div_neg", SP, DIV, 32'hFFFFFFF9, 32'd2, DC, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("div_negdiv", SP, DIV, 32'd7, 32'hFFFFFFFE, DC, 32'h00000001, 32'hFFFFFFFD);
        run_op("divu_zero", SP, DIVU, 32'd9, 32'd0, DC, 32'd9, 32'hFFFFFFFF);
        run_op("div_zero", SP, DIV, 32'hFFFFFFFB, 32'd0, DC, 32'hFFFFFFFB, 32'hFFFFFFFF);
        run_op("div_ovf", SP, DIV, 32'h80000000, 32'hFFFFFFFF, DC, 32'h0, 32'h80000000);
        run_op("divu_big", SP, DIVU, 32'hFFFFFFF9, 32'd2, DC, 32'h1, 32'h7FFFFFFC);
        test_reset_mid;
        test_madd;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
